// File: rtl/warp_ibuf_pkg.sv
// Shared types and derived-width helpers for the per-warp instruction buffer.
package warp_ibuf_pkg;

  // Packed decoded bundle. The fields total 256 bits, the default payload width.
  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  wid;
    logic [7:0]  op;
    logic [7:0]  rd;
    logic [7:0]  rs1;
    logic [7:0]  rs2;
    logic [7:0]  rs3;
    logic [31:0] imm32;
    logic [23:0] imm24;
    logic [7:0]  csrImm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  pred;
    logic [31:0] tmask;
    logic [31:0] raw;
  } ibuf_entry_t;

  localparam int IBUF_ENTRY_BITS = $bits(ibuf_entry_t);

  function automatic int warp_id_bits(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/warp_ibuffer_if.sv
// Decode-to-issue bundle for warp_ibuffer: enqueue port, per-warp heads, flush and occupancy.
interface warp_ibuffer_if
  import warp_ibuf_pkg::*;
#(
  parameter int NUM_WARPS    = 8,
  parameter int DEPTH        = 4,
  parameter int PAYLOAD_BITS = IBUF_ENTRY_BITS
) ();

  localparam int WARP_ID_BITS = warp_id_bits(NUM_WARPS);
  localparam int CNT_BITS     = cnt_bits(DEPTH);

  logic                              enq_valid;
  logic                              enq_ready;
  logic [WARP_ID_BITS-1:0]           enq_wid;
  logic [PAYLOAD_BITS-1:0]           enq_bits;
  logic [NUM_WARPS-1:0]              deq_valid;
  logic [NUM_WARPS-1:0]              deq_ready;
  logic [NUM_WARPS*PAYLOAD_BITS-1:0] deq_bits;
  logic [NUM_WARPS-1:0]              flush;
  logic [NUM_WARPS*CNT_BITS-1:0]     count;
  logic [NUM_WARPS-1:0]              space;
  logic                              all_empty;

  // Frontend/issue side.
  modport master (
    output enq_valid, enq_wid, enq_bits, deq_ready, flush,
    input  enq_ready, deq_valid, deq_bits, count, space, all_empty
  );

  // Buffer side.
  modport slave (
    input  enq_valid, enq_wid, enq_bits, deq_ready, flush,
    output enq_ready, deq_valid, deq_bits, count, space, all_empty
  );

endinterface

// File: rtl/warp_ibuf_fifo.sv
// Single-warp FIFO with flush and occupancy count.
// WARP_IBUF_BYPASS_EN adds an empty-FIFO enqueue-to-head combinational bypass.
module warp_ibuf_fifo
  import warp_ibuf_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PAYLOAD_BITS = IBUF_ENTRY_BITS,
  localparam int CNT_BITS    = cnt_bits(DEPTH),
  localparam int PTR_BITS    = ptr_bits(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enq_i,
  input  logic [PAYLOAD_BITS-1:0] enq_data_i,
  input  logic                    deq_ready_i,
  input  logic                    flush_i,
  output logic                    deq_valid_o,
  output logic [PAYLOAD_BITS-1:0] deq_data_o,
  output logic [CNT_BITS-1:0]     count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0]     rptr_q, rptr_d;
  logic [PTR_BITS-1:0]     wptr_q, wptr_d;
  logic [CNT_BITS-1:0]     count_q, count_d;
  logic                    deq_fire;
  logic                    wr_en;
  logic                    rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_BITS'(DEPTH));
  assign count_o = count_q;

`ifdef WARP_IBUF_BYPASS_EN
  logic pass;

  assign deq_valid_o = !empty_o || enq_i;
  assign deq_data_o  = empty_o ? enq_data_i : mem_q[rptr_q];
  assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;
  // An entry consumed in the cycle it arrives at an empty FIFO never touches storage.
  assign pass        = empty_o && enq_i && deq_fire;
  assign wr_en       = enq_i && !flush_i && !pass;
  assign rd_en       = deq_fire && !pass;
`else
  assign deq_valid_o = !empty_o;
  assign deq_data_o  = mem_q[rptr_q];
  assign deq_fire    = deq_valid_o && deq_ready_i && !flush_i;
  assign wr_en       = enq_i && !flush_i;
  assign rd_en       = deq_fire;
`endif

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_BITS'(1);
      if (rd_en) rptr_d = rptr_q + PTR_BITS'(1);
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer: enqueue demux, NUM_WARPS FIFOs, space/all-empty reduction.
// Optional macro WARP_IBUF_BYPASS_EN enables the empty-FIFO bypass inside each FIFO.
module warp_ibuffer
  import warp_ibuf_pkg::*;
#(
  parameter int NUM_WARPS    = 8,
  parameter int DEPTH        = 4,
  parameter int PAYLOAD_BITS = IBUF_ENTRY_BITS
) (
  input  logic          clock,
  input  logic          reset,
  warp_ibuffer_if.slave ib
);

  localparam int WARP_ID_BITS = warp_id_bits(NUM_WARPS);
  localparam int CNT_BITS     = cnt_bits(DEPTH);

  logic [NUM_WARPS-1:0]    enq_sel;
  logic [NUM_WARPS-1:0]    full;
  logic [NUM_WARPS-1:0]    empty;
  logic [NUM_WARPS-1:0]    deq_valid;
  logic [PAYLOAD_BITS-1:0] deq_data [NUM_WARPS];
  logic [CNT_BITS-1:0]     count    [NUM_WARPS];
  logic                    wid_ok;
  logic                    wid_blocked;
  logic                    enq_ready;

  // enq_ready depends only on registered fullness and flush, never on deq_ready.
  always_comb begin
    wid_ok      = 1'b0;
    wid_blocked = 1'b0;
    for (int g = 0; g < NUM_WARPS; g++) begin
      if (ib.enq_wid == WARP_ID_BITS'(g)) begin
        wid_ok      = 1'b1;
        wid_blocked = full[g] || ib.flush[g];
      end
    end
    enq_ready = wid_ok && !wid_blocked;
  end

  always_comb begin
    enq_sel = '0;
    for (int g = 0; g < NUM_WARPS; g++) begin
      enq_sel[g] = ib.enq_valid && enq_ready && (ib.enq_wid == WARP_ID_BITS'(g));
    end
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    warp_ibuf_fifo #(
      .DEPTH        (DEPTH),
      .PAYLOAD_BITS (PAYLOAD_BITS)
    ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .enq_i       (enq_sel[g]),
      .enq_data_i  (ib.enq_bits),
      .deq_ready_i (ib.deq_ready[g]),
      .flush_i     (ib.flush[g]),
      .deq_valid_o (deq_valid[g]),
      .deq_data_o  (deq_data[g]),
      .count_o     (count[g]),
      .full_o      (full[g]),
      .empty_o     (empty[g])
    );
  end

  always_comb begin
    ib.deq_bits = '0;
    ib.count    = '0;
    for (int g = 0; g < NUM_WARPS; g++) begin
      ib.deq_bits[PAYLOAD_BITS*g +: PAYLOAD_BITS] = deq_data[g];
      ib.count[CNT_BITS*g +: CNT_BITS]            = count[g];
    end
  end

  assign ib.enq_ready = enq_ready;
  assign ib.deq_valid = deq_valid;
  assign ib.space     = ~full;
  assign ib.all_empty = &empty;

endmodule

// File: tb/tb_warp_ibuffer.sv
// Bench for warp_ibuffer: vector table, hand corner sequences and a random run against a queue model.
module tb_warp_ibuffer;
  import warp_ibuf_pkg::*;

  localparam int NW    = 8;
  localparam int DEPTH = 4;
  localparam int PB    = 256;
  localparam int CB    = cnt_bits(DEPTH);

  typedef logic [PB-1:0] word_t;

  typedef struct packed {
    logic          ev;
    logic [2:0]    wid;
    logic [7:0]    tag;
    logic [NW-1:0] dr;
    logic          rdy;
    logic          dv3;
    logic [7:0]    head3;
    logic [CB-1:0] cnt3;
  } vec_t;

`ifdef WARP_IBUF_BYPASS_EN
  localparam int STREAM_CNT = 0;
  localparam bit BYP = 1'b1;
`else
  localparam int STREAM_CNT = 1;
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  warp_ibuffer_if #(.NUM_WARPS(NW), .DEPTH(DEPTH), .PAYLOAD_BITS(PB)) ib ();

  warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (
    .clock (clock),
    .reset (reset),
    .ib    (ib)
  );

  word_t mq [NW][$];
  int    total = 0;
  int    bad   = 0;
  vec_t  tbl [13];

  task automatic chk(input string nm, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CB-1:0] cnt_of(input int g);
    return ib.count[CB*g +: CB];
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    for (int i = 0; i < PB/32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic vec_t mk(input logic ev, input logic [2:0] wid, input logic [7:0] tag,
                              input logic [NW-1:0] dr, input logic rdy, input logic dv3,
                              input logic [7:0] head3, input logic [CB-1:0] cnt3);
    vec_t v;
    v.ev = ev; v.wid = wid; v.tag = tag; v.dr = dr;
    v.rdy = rdy; v.dv3 = dv3; v.head3 = head3; v.cnt3 = cnt3;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [2:0] wid, input word_t bits,
                       input logic [NW-1:0] dr, input logic [NW-1:0] fl);
    ib.enq_valid = ev;
    ib.enq_wid   = wid;
    ib.enq_bits  = bits;
    ib.deq_ready = dr;
    ib.flush     = fl;
  endtask

  // One cycle: compare DUT against the queue model, then advance both across a clock edge.
  task automatic step(input logic ev, input logic [2:0] wid, input word_t bits,
                      input logic [NW-1:0] dr, input logic [NW-1:0] fl);
    logic            m_rdy, fire, pass;
    logic [NW-1:0]   m_dv, m_sp;
    logic [NW*CB-1:0] m_cnt;
    int               n_total;
    drive(ev, wid, bits, dr, fl);
    #1;
    m_rdy   = (mq[wid].size() < DEPTH) && !fl[wid];
    fire    = ev && m_rdy;
    n_total = 0;
    for (int g = 0; g < NW; g++) begin
      m_dv[g] = (mq[g].size() != 0) || (BYP && fire && (int'(wid) == g));
      m_sp[g] = mq[g].size() < DEPTH;
      m_cnt[CB*g +: CB] = CB'(mq[g].size());
      n_total += mq[g].size();
    end
    chk("enq_ready", word_t'(ib.enq_ready), word_t'(m_rdy));
    chk("deq_valid", word_t'(ib.deq_valid), word_t'(m_dv));
    chk("count", word_t'(ib.count), word_t'(m_cnt));
    chk("space", word_t'(ib.space), word_t'(m_sp));
    chk("all_empty", word_t'(ib.all_empty), word_t'(n_total == 0));
    for (int g = 0; g < NW; g++) begin
      if (m_dv[g])
        chk($sformatf("deq_bits[%0d]", g), ib.deq_bits[PB*g +: PB],
            (mq[g].size() != 0) ? mq[g][0] : bits);
    end
    for (int g = 0; g < NW; g++) begin
      if (fl[g]) begin
        mq[g].delete();
      end else begin
        pass = 1'b0;
        if (m_dv[g] && dr[g]) begin
          if (mq[g].size() == 0) pass = 1'b1;
          else void'(mq[g].pop_front());
        end
        if (fire && (int'(wid) == g) && !pass) mq[g].push_back(bits);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    word_t v0, v2, w;
    logic [NW-1:0] fl, dr;

    tbl[0]  = mk(1'b1, 3'd3, 8'h0A, 8'h00, 1'b1, BYP,  BYP ? 8'h0A : 8'h00, 3'd1);
    tbl[1]  = mk(1'b1, 3'd3, 8'h0B, 8'h00, 1'b1, 1'b1, 8'h0A, 3'd2);
    tbl[2]  = mk(1'b1, 3'd3, 8'h0C, 8'h00, 1'b1, 1'b1, 8'h0A, 3'd3);
    tbl[3]  = mk(1'b1, 3'd3, 8'h0D, 8'h00, 1'b1, 1'b1, 8'h0A, 3'd4);
    tbl[4]  = mk(1'b1, 3'd2, 8'h09, 8'h00, 1'b1, 1'b1, 8'h0A, 3'd4);
    tbl[5]  = mk(1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 1'b1, 8'h0A, 3'd4);
    tbl[6]  = mk(1'b1, 3'd3, 8'h0E, 8'h08, 1'b0, 1'b1, 8'h0A, 3'd3);
    tbl[7]  = mk(1'b1, 3'd3, 8'h0E, 8'h00, 1'b1, 1'b1, 8'h0B, 3'd4);
    tbl[8]  = mk(1'b0, 3'd3, 8'h00, 8'h08, 1'b0, 1'b1, 8'h0B, 3'd3);
    tbl[9]  = mk(1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 1'b1, 8'h0C, 3'd2);
    tbl[10] = mk(1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 1'b1, 8'h0D, 3'd1);
    tbl[11] = mk(1'b0, 3'd3, 8'h00, 8'h08, 1'b1, 1'b1, 8'h0E, 3'd0);
    tbl[12] = mk(1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0);

    drive(1'b0, 3'd0, '0, '0, '0);
    #12;
    chk("rst enq_ready", word_t'(ib.enq_ready), word_t'(1'b1));
    chk("rst deq_valid", word_t'(ib.deq_valid), '0);
    chk("rst space", word_t'(ib.space), word_t'({NW{1'b1}}));
    chk("rst all_empty", word_t'(ib.all_empty), word_t'(1'b1));
    chk("rst count", word_t'(ib.count), '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Fill warp 3, refuse while full, then drain in order.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ev, tbl[i].wid, {32{tbl[i].tag}}, tbl[i].dr, '0);
      #1;
      chk($sformatf("tbl%0d enq_ready", i), word_t'(ib.enq_ready), word_t'(tbl[i].rdy));
      chk($sformatf("tbl%0d dv3", i), word_t'(ib.deq_valid[3]), word_t'(tbl[i].dv3));
      if (tbl[i].dv3)
        chk($sformatf("tbl%0d head3", i), ib.deq_bits[PB*3 +: PB], {32{tbl[i].head3}});
      step(tbl[i].ev, tbl[i].wid, {32{tbl[i].tag}}, tbl[i].dr, '0);
      chk($sformatf("tbl%0d cnt3", i), word_t'(cnt_of(3)), word_t'(tbl[i].cnt3));
    end

    // Pointer wrap on warp 1.
    step(1'b0, 3'd0, '0, '0, '1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) step(1'b1, 3'd1, rnd_word(), '0, '0);
      chk("wrap full", word_t'(cnt_of(1)), word_t'(DEPTH));
      for (int k = 0; k < DEPTH; k++) step(1'b0, 3'd0, '0, 8'h02, '0);
      chk("wrap drained", word_t'(cnt_of(1)), '0);
    end

    // Flush of warp 5 overrides both dequeue and enqueue; warp 0 untouched.
    v0 = rnd_word();
    step(1'b1, 3'd5, rnd_word(), '0, '0);
    step(1'b1, 3'd5, rnd_word(), '0, '0);
    step(1'b1, 3'd0, v0, '0, '0);
    drive(1'b1, 3'd5, rnd_word(), 8'h20, 8'h20);
    #1;
    chk("flush enq_ready", word_t'(ib.enq_ready), '0);
    step(1'b1, 3'd5, ib.enq_bits, 8'h20, 8'h20);
    chk("flush cnt5", word_t'(cnt_of(5)), '0);
    chk("flush dv5", word_t'(ib.deq_valid[5]), '0);
    chk("flush cnt0", word_t'(cnt_of(0)), word_t'(1));
    chk("flush head0", ib.deq_bits[0 +: PB], v0);

    // Streaming enqueue+dequeue on warp 2.
    step(1'b0, 3'd0, '0, '0, '1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'd2, rnd_word(), 8'h04, '0);
      chk($sformatf("stream%0d cnt2", k), word_t'(cnt_of(2)), word_t'(STREAM_CNT));
    end

    // Random traffic against the model.
    step(1'b0, 3'd0, '0, '0, '1);
    for (int k = 0; k < 400; k++) begin
      fl = '0;
      for (int b = 0; b < NW; b++) if ($urandom_range(0, 15) == 0) fl[b] = 1'b1;
      dr = NW'($urandom);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, NW-1)), rnd_word(), dr, fl);
    end

    // Asynchronous reset with entries in warps 0, 4, 7.
    step(1'b0, 3'd0, '0, '0, '1);
    for (int k = 0; k < 6; k++) step(1'b1, (k < 2) ? 3'd0 : (k < 4) ? 3'd4 : 3'd7, rnd_word(), '0, '0);
    chk("pre-rst all_empty", word_t'(ib.all_empty), '0);
    #2;
    reset = 1'b0;
    #1;
    chk("async all_empty", word_t'(ib.all_empty), word_t'(1'b1));
    chk("async deq_valid", word_t'(ib.deq_valid), '0);
    chk("async count", word_t'(ib.count), '0);
    for (int g = 0; g < NW; g++) mq[g].delete();
    @(negedge clock);
    reset = 1'b1;
    v2 = rnd_word();
    drive(1'b1, 3'd4, v2, '0, '0);
    @(posedge clock);
    #1;
    mq[4].push_back(v2);
    chk("post-rst cnt4", word_t'(cnt_of(4)), word_t'(1));
    w = v2;
    step(1'b0, 3'd0, '0, 8'h10, '0);
    chk("post-rst drained", word_t'(cnt_of(4)), '0);
    chk("post-rst data", w, mq[4].size() == 0 ? v2 : '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
